// File: rtl/rf_pkg.sv
// Shared constants and the write-entry type for the register-file write queue.
// Exports AW, DW, NREGS, ZERO_REG and wr_entry_t.
package rf_pkg;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NREGS = 32;

   localparam logic [AW-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
   } wr_entry_t;

endpackage

// File: rtl/rf_write_queue_if.sv
// Writeback request handshake into the register-file write queue.
// Signals: in_valid/in_ready handshake, in_wa destination, in_wd data.
interface rf_write_queue_if #(
   parameter int AW = 5,
   parameter int DW = 32
);

   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_wa;
   logic [DW-1:0] in_wd;

   modport master (
      output in_valid,
      output in_wa,
      output in_wd,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_wa,
      input  in_wd,
      output in_ready
   );

endinterface

// File: rtl/rf_fwd_match.sv
// Youngest-match search over the occupied queue entries for one lookup address.
// Inputs: entry arrays, rd_ptr, count, ra. Outputs: hit, data (0 on miss).
module rf_fwd_match
   import rf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = rf_pkg::AW,
   parameter int DW    = rf_pkg::DW,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0] wa [DEPTH],
   input  logic [DW-1:0] wd [DEPTH],
   input  logic [PW-1:0] rd_ptr,
   input  logic [PW:0]   count,
   input  logic [AW-1:0] ra,
   output logic          hit,
   output logic [DW-1:0] data
);

   localparam int CW = PW + 1;

   logic [PW-1:0] idx;

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (ra != AW'(ZERO_REG) && CW'(i) < count
             && wa[idx] == ra) begin
            hit  = 1'b1;
            data = wd[idx];
         end
      end
   end

endmodule

// File: rtl/rf_write_queue.sv
// In-order write queue feeding the register file write port, with forwarding.
// Ports: clk, rst_n, wb (request handshake), drain_en, rf_we/wa/wd, ra1/ra2 lookups, fwd*, count.
module rf_write_queue
   import rf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = rf_pkg::AW,
   parameter int DW    = rf_pkg::DW
) (
   input  logic                     clk,
   input  logic                     rst_n,
   rf_write_queue_if.slave          wb,
   input  logic                     drain_en,
   output logic                     rf_we,
   output logic [AW-1:0]            rf_wa,
   output logic [DW-1:0]            rf_wd,
   input  logic [AW-1:0]            ra1,
   input  logic [AW-1:0]            ra2,
   output logic                     fwd1_hit,
   output logic [DW-1:0]            fwd1_data,
   output logic                     fwd2_hit,
   output logic [DW-1:0]            fwd2_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
   } ent_t;

   ent_t          mem [DEPTH];
   logic [AW-1:0] wa_v [DEPTH];
   logic [DW-1:0] wd_v [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   logic accept;
   logic push;
   logic pop;

   // Full blocks the request even when the head drains this same cycle.
   assign wb.in_ready = (count != CW'(DEPTH));

   // Requests to r0 complete the handshake but are simply dropped.
   assign accept = wb.in_valid && wb.in_ready;
   assign push   = accept && (wb.in_wa != AW'(ZERO_REG));
   assign pop    = rf_we;

   assign rf_we = drain_en && (count != '0);
   assign rf_wa = mem[rd_ptr].wa;
   assign rf_wd = mem[rd_ptr].wd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Entry storage carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{wa: wb.in_wa, wd: wb.in_wd};
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         wa_v[i] = mem[i].wa;
         wd_v[i] = mem[i].wd;
      end
   end

   rf_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd1 (
      .wa     (wa_v),
      .wd     (wd_v),
      .rd_ptr (rd_ptr),
      .count  (count),
      .ra     (ra1),
      .hit    (fwd1_hit),
      .data   (fwd1_data)
   );

   rf_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd2 (
      .wa     (wa_v),
      .wd     (wd_v),
      .rd_ptr (rd_ptr),
      .count  (count),
      .ra     (ra2),
      .hit    (fwd2_hit),
      .data   (fwd2_data)
   );

endmodule
